// File: rtl/branch_predictor_ctrl_if.sv
// Fetch/execute/hazard-side signal bundle of the gshare branch predictor controller.
// The master drives fetch and execute information, and the slave is the predictor itself.
interface branch_predictor_ctrl_if #(
  parameter int GHR_WIDTH = 6
);
  logic [31:0]          pc_f_i;
  logic [31:0]          pc_ex_i;
  logic [GHR_WIDTH-1:0] ghr_ex_i;
  logic                 branch_op_ex_i;
  logic                 pc_src_res_ex_i;
  logic                 pc_src_pred_ex_i;
  logic                 stall_ex_i;
  logic                 flush_table_i;
  logic                 pc_src_pred_f_o;
  logic [GHR_WIDTH-1:0] ghr_f_o;
  logic                 mispredict_ex_o;
  logic                 ready_o;
  logic                 ctrl_state_o;   // debug: 0 = INIT, 1 = RUN

  modport master (
    output pc_f_i, pc_ex_i, ghr_ex_i, branch_op_ex_i, pc_src_res_ex_i,
           pc_src_pred_ex_i, stall_ex_i, flush_table_i,
    input  pc_src_pred_f_o, ghr_f_o, mispredict_ex_o, ready_o, ctrl_state_o
  );

  modport slave (
    input  pc_f_i, pc_ex_i, ghr_ex_i, branch_op_ex_i, pc_src_res_ex_i,
           pc_src_pred_ex_i, stall_ex_i, flush_table_i,
    output pc_src_pred_f_o, ghr_f_o, mispredict_ex_o, ready_o, ctrl_state_o
  );
endinterface

// File: rtl/branch_predictor_ctrl.sv
// Gshare branch predictor: 2-bit saturating counter table, init walk after reset/flush,
// non-speculative GHR updated on resolved branches, and the mispredict flag for the hazard unit.
// Handshake: there is no valid/ready pairing. ready_o=1 means fetch predictions are valid.
// An EX update is accepted on any edge where ready_o & branch_op_ex_i & !stall_ex_i & !flush_table_i.
module branch_predictor_ctrl #(
  parameter int         INDEX_WIDTH = 6,
  parameter int         GHR_WIDTH   = 6,
  parameter logic [1:0] INIT_STATE  = 2'b01
) (
  input logic                   clk_i,
  input logic                   reset_i,
  branch_predictor_ctrl_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_WIDTH;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_idx_q, init_idx_d;
  logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
  logic [1:0]             table_q [ENTRIES];

  logic                   tbl_we;
  logic [INDEX_WIDTH-1:0] tbl_waddr;
  logic [1:0]             tbl_wdata;
  logic [INDEX_WIDTH-1:0] idx_f, idx_ex;
  logic                   run;

  function automatic logic [INDEX_WIDTH-1:0] idx_of(input logic [INDEX_WIDTH-1:0] pc_bits,
                                                    input logic [GHR_WIDTH-1:0]   g);
    logic [INDEX_WIDTH-1:0] gx;
    gx = INDEX_WIDTH'(g);
    return pc_bits ^ gx;
  endfunction

  function automatic logic [1:0] sat_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign idx_f  = idx_of(bp.pc_f_i[INDEX_WIDTH+1:2], ghr_q);
  assign idx_ex = idx_of(bp.pc_ex_i[INDEX_WIDTH+1:2], bp.ghr_ex_i);
  assign run    = (state_q == ST_RUN);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ghr_d      = ghr_q;
    tbl_we     = 1'b0;
    tbl_waddr  = init_idx_q;
    tbl_wdata  = INIT_STATE;
    case (state_q)
      ST_INIT: begin
        tbl_we = 1'b1;
        if (bp.flush_table_i) begin
          init_idx_d = '0;
          ghr_d      = '0;
        end else begin
          // The index wraps to 0 on the last entry, which leaves it ready for the next flush.
          init_idx_d = init_idx_q + 1'b1;
          if (init_idx_q == INDEX_WIDTH'(ENTRIES - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bp.flush_table_i) begin
          state_d    = ST_INIT;
          init_idx_d = '0;
          ghr_d      = '0;
        end else if (bp.branch_op_ex_i && !bp.stall_ex_i) begin
          tbl_we    = 1'b1;
          tbl_waddr = idx_ex;
          tbl_wdata = sat_next(table_q[idx_ex], bp.pc_src_res_ex_i);
          ghr_d     = {ghr_q[GHR_WIDTH-2:0], bp.pc_src_res_ex_i};
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Counters are deliberately unreset; the init walk gives them a defined value.
  always_ff @(posedge clk_i) begin
    if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
  end

  // Fetch reads the registered array, so a same-cycle update shows up one cycle later.
  assign bp.pc_src_pred_f_o = run & table_q[idx_f][1];
  assign bp.ghr_f_o         = ghr_q;
  assign bp.ready_o         = run;
  assign bp.mispredict_ex_o = bp.branch_op_ex_i & run &
                              (bp.pc_src_pred_ex_i != bp.pc_src_res_ex_i);
  assign bp.ctrl_state_o    = state_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pc_f_i[31:INDEX_WIDTH+2], bp.pc_f_i[1:0],
                            bp.pc_ex_i[31:INDEX_WIDTH+2], bp.pc_ex_i[1:0]};
endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed self-checking bench for branch_predictor_ctrl: vector tables for steady-state
// prediction/update behaviour plus hand-written init, flush and async-reset sequences.
module tb_branch_predictor_ctrl;
  logic clk_i;
  logic reset_i;

  branch_predictor_ctrl_if #(.GHR_WIDTH(6)) bp ();

  branch_predictor_ctrl #(.INDEX_WIDTH(6), .GHR_WIDTH(6), .INIT_STATE(2'b01)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bp     (bp.slave)
  );

  // ---------------- clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];   // {ready, pred, mis, ghr[5:0]}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string name);
    logic [8:0] e;
    e = exp_q.pop_front();
    chk({name, ".ready"}, 32'(bp.ready_o),         32'(e[8]));
    chk({name, ".pred"},  32'(bp.pc_src_pred_f_o), 32'(e[7]));
    chk({name, ".mis"},   32'(bp.mispredict_ex_o), 32'(e[6]));
    chk({name, ".ghr"},   32'(bp.ghr_f_o),         32'(e[5:0]));
  endtask

  // ---------------- driver tasks
  function automatic logic [31:0] pc_for(input logic [5:0] idx_field);
    logic [23:0] hi;
    logic [1:0]  lo;
    hi = 24'($urandom_range(0, 24'hFF_FFFF));
    lo = 2'($urandom_range(0, 3));
    return {hi, idx_field, lo};
  endfunction

  task automatic drive_idle();
    bp.pc_f_i           = 32'h0;
    bp.pc_ex_i          = 32'h0;
    bp.ghr_ex_i         = 6'h0;
    bp.branch_op_ex_i   = 1'b0;
    bp.pc_src_res_ex_i  = 1'b0;
    bp.pc_src_pred_ex_i = 1'b0;
    bp.stall_ex_i       = 1'b0;
    bp.flush_table_i    = 1'b0;
  endtask

  // Counts rising edges until ready_o is seen high; bounded so a dead DUT cannot hang the run.
  task automatic wait_ready(input string name, input int exp_cycles);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk_i);
      #1;
      cyc++;
    end while (!bp.ready_o && cyc < 200);
    chk({name, ".init_cycles"}, 32'(cyc), 32'(exp_cycles));
  endtask

  typedef struct {
    logic       bop, res, pex, stall;
    logic [5:0] ex_idx, ghr_ex, f_idx;
    logic       exp_pred, exp_mis;
    logic [5:0] exp_ghr;
  } vec_t;

  function automatic vec_t mk(input logic bop, res, pex, stall,
                              input logic [5:0] ex_idx, ghr_ex, f_idx,
                              input logic exp_pred, exp_mis, input logic [5:0] exp_ghr);
    vec_t v;
    v.bop = bop; v.res = res; v.pex = pex; v.stall = stall;
    v.ex_idx = ex_idx; v.ghr_ex = ghr_ex; v.f_idx = f_idx;
    v.exp_pred = exp_pred; v.exp_mis = exp_mis; v.exp_ghr = exp_ghr;
    return v;
  endfunction

  // Drives one vector at the falling edge, checks the combinational outputs, then lets
  // the rising edge commit the update. Fetch PC is chosen so idx_f == f_idx under exp_ghr.
  task automatic apply_vec(input string name, input vec_t v);
    @(negedge clk_i);
    bp.branch_op_ex_i   = v.bop;
    bp.pc_src_res_ex_i  = v.res;
    bp.pc_src_pred_ex_i = v.pex;
    bp.stall_ex_i       = v.stall;
    bp.flush_table_i    = 1'b0;
    bp.pc_ex_i          = pc_for(v.ex_idx);
    bp.ghr_ex_i         = v.ghr_ex;
    bp.pc_f_i           = pc_for(v.f_idx ^ v.exp_ghr);
    #1;
    exp_q.push_back({1'b1, v.exp_pred, v.exp_mis, v.exp_ghr});
    chk_outputs(name);
  endtask

  vec_t vt_a [18];
  vec_t vt_b [6];

  initial begin
    //              bop res pex stl ex_idx ghr_ex f_idx  pred mis ghr
    vt_a[0]  = mk(1, 1, 0, 0, 6'h10, 6'h00, 6'h10, 0, 1, 6'h00);
    vt_a[1]  = mk(1, 1, 0, 0, 6'h10, 6'h00, 6'h10, 1, 1, 6'h01);
    vt_a[2]  = mk(1, 1, 0, 0, 6'h10, 6'h00, 6'h10, 1, 1, 6'h03);
    vt_a[3]  = mk(0, 0, 0, 0, 6'h10, 6'h00, 6'h10, 1, 0, 6'h07);
    vt_a[4]  = mk(1, 0, 1, 0, 6'h10, 6'h00, 6'h10, 1, 1, 6'h07);
    vt_a[5]  = mk(1, 0, 1, 0, 6'h10, 6'h00, 6'h10, 1, 1, 6'h0E);
    vt_a[6]  = mk(0, 0, 0, 0, 6'h00, 6'h00, 6'h10, 0, 0, 6'h1C);
    vt_a[7]  = mk(1, 1, 1, 0, 6'h20, 6'h00, 6'h20, 0, 0, 6'h1C);
    vt_a[8]  = mk(1, 1, 1, 0, 6'h20, 6'h00, 6'h20, 1, 0, 6'h39);
    vt_a[9]  = mk(0, 0, 0, 0, 6'h00, 6'h00, 6'h20, 1, 0, 6'h33);
    vt_a[10] = mk(1, 1, 0, 0, 6'h21, 6'h00, 6'h21, 0, 1, 6'h33);
    vt_a[11] = mk(0, 0, 0, 0, 6'h00, 6'h00, 6'h21, 1, 0, 6'h27);
    vt_a[12] = mk(1, 0, 1, 1, 6'h21, 6'h00, 6'h21, 1, 1, 6'h27);
    vt_a[13] = mk(0, 0, 0, 0, 6'h00, 6'h00, 6'h21, 1, 0, 6'h27);
    vt_a[14] = mk(1, 0, 0, 0, 6'h05, 6'h25, 6'h20, 1, 0, 6'h27);
    vt_a[15] = mk(0, 0, 0, 0, 6'h00, 6'h00, 6'h20, 1, 0, 6'h0E);
    vt_a[16] = mk(1, 0, 0, 0, 6'h20, 6'h00, 6'h20, 1, 0, 6'h0E);
    vt_a[17] = mk(0, 0, 0, 0, 6'h00, 6'h00, 6'h20, 0, 0, 6'h1C);

    vt_b[0]  = mk(1, 1, 1, 0, 6'h30, 6'h00, 6'h30, 0, 0, 6'h00);
    vt_b[1]  = mk(1, 0, 0, 1, 6'h30, 6'h00, 6'h30, 1, 0, 6'h01);
    vt_b[2]  = mk(1, 0, 1, 0, 6'h31, 6'h00, 6'h30, 1, 1, 6'h01);
    vt_b[3]  = mk(1, 1, 0, 0, 6'h31, 6'h00, 6'h31, 0, 1, 6'h02);
    vt_b[4]  = mk(0, 0, 0, 0, 6'h00, 6'h00, 6'h31, 0, 0, 6'h05);
    vt_b[5]  = mk(0, 0, 1, 0, 6'h00, 6'h00, 6'h31, 0, 0, 6'h05);

    // ---- reset values, with a would-be mispredict on the EX inputs
    drive_idle();
    reset_i = 1'b1;
    bp.branch_op_ex_i   = 1'b1;
    bp.pc_src_pred_ex_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 6'h00});
    chk_outputs("reset");
    reset_i = 1'b0;
    drive_idle();

    // ---- init walk, then every entry reads WU
    wait_ready("init", 64);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      bp.pc_f_i = pc_for(6'(i));
      #1;
      chk($sformatf("init_wu[%0d]", i), 32'(bp.pc_src_pred_f_o), 32'd0);
    end

    // ---- saturation, read-during-write, stall, ghr_ex indexing
    for (int i = 0; i < 18; i++) apply_vec($sformatf("vec_a%0d", i), vt_a[i]);

    // ---- flush in RUN with a simultaneous update
    @(negedge clk_i);
    bp.flush_table_i    = 1'b1;
    bp.branch_op_ex_i   = 1'b1;
    bp.pc_src_res_ex_i  = 1'b1;
    bp.pc_src_pred_ex_i = 1'b1;
    bp.pc_ex_i          = pc_for(6'h10);
    bp.ghr_ex_i         = 6'h00;
    @(posedge clk_i);
    #1;
    chk("flush.ready", 32'(bp.ready_o), 32'd0);
    chk("flush.ghr",   32'(bp.ghr_f_o), 32'd0);
    @(negedge clk_i);
    drive_idle();
    wait_ready("flush", 64);

    // ---- flush again on the 30th cycle of init
    @(negedge clk_i);
    bp.flush_table_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    drive_idle();
    repeat (29) @(posedge clk_i);
    @(negedge clk_i);
    bp.branch_op_ex_i   = 1'b1;
    bp.pc_src_pred_ex_i = 1'b1;
    bp.pc_src_res_ex_i  = 1'b0;
    bp.pc_f_i           = pc_for(6'h10);
    #1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 6'h00});
    chk_outputs("init_mid");
    bp.flush_table_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    drive_idle();
    wait_ready("reflush", 64);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      bp.pc_f_i = pc_for(6'(i));
      #1;
      chk($sformatf("reflush_wu[%0d]", i), 32'(bp.pc_src_pred_f_o), 32'd0);
    end

    // ---- GHR shifting from zero with a stalled branch, mispredict gating
    for (int i = 0; i < 6; i++) apply_vec($sformatf("vec_b%0d", i), vt_b[i]);

    // ---- async reset mid-run takes effect without a clock edge
    @(negedge clk_i);
    bp.branch_op_ex_i   = 1'b1;
    bp.pc_src_pred_ex_i = 1'b1;
    bp.pc_src_res_ex_i  = 1'b0;
    bp.pc_f_i           = pc_for(6'h31 ^ 6'h05);
    #1;
    chk("pre_areset.mis", 32'(bp.mispredict_ex_o), 32'd1);
    #1;
    reset_i = 1'b1;
    #1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 6'h00});
    chk_outputs("areset");
    @(negedge clk_i);
    reset_i = 1'b0;
    drive_idle();
    wait_ready("areset", 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
